// File: rtl/cache_pkg.sv
// Shared widths, address layout and FSM encoding for the 2-way cache controller.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package cache_pkg;

    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = 512;
    localparam int TAG_W          = 20;
    localparam int INDEX_W        = 6;
    localparam int OFFSET_W       = 6;
    localparam int SETS           = 1 << INDEX_W;
    localparam int WORDS_PER_LINE = LINE_W / WORD_W;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] index_t;

    // CPU byte address split into its cache fields.
    typedef struct packed {
        tag_t       tag;
        index_t     index;
        logic [3:0] word;
        logic [1:0] byte_off;
    } addr_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK_HIT,
        RD_REQ,
        RD_WAIT,
        FILL,
        WR_REQ,
        WR_WAIT
    } state_t;

    // Select one 32-bit word out of a 512-bit line; sel*32 built as a 9-bit concat.
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [3:0]         sel);
        return line[{sel, 5'd0} +: WORD_W];
    endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Tag/valid store for 64 sets x 2 ways plus one LRU (next-victim) bit per set.
// Latency: lookup is combinational; fill/touch/invalidate take effect at the next clk edge.
// Backpressure: none; the controller issues at most one update per cycle.
//
// Ports:
//   clk, rst_n   clock and async active-low reset (clears valid and LRU bits only)
//   index        set addressed by lookup, touch, fill and invalidate
//   lookup_tag   tag compared against both ways -> hit
//   touch_en     read hit: mark the hitting way most recently used
//   inv_en       write hit: clear the valid bit of the hitting way
//   fill_en      line fill: install lookup_tag into the victim way, then flip LRU
//   lru_store    per-set next-victim way, exported for observation
module cache_tag_array
    import cache_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  index_t          index,
    input  tag_t            lookup_tag,
    output logic            hit,
    input  logic            touch_en,
    input  logic            inv_en,
    input  logic            fill_en,
    output logic [SETS-1:0] lru_store
);

    tag_t       tag_store   [0:SETS-1][0:1];
    logic [1:0] valid_store [0:SETS-1];

    logic hit0;
    logic hit1;
    logic hit_way;
    logic victim_way;

    assign hit0       = valid_store[index][0] && (tag_store[index][0] == lookup_tag);
    assign hit1       = valid_store[index][1] && (tag_store[index][1] == lookup_tag);
    assign hit        = hit0 || hit1;
    // Way 0 wins if both matched; fills never create duplicate tags in a set.
    assign hit_way    = !hit0;
    assign victim_way = lru_store[index];

    // Tags need no reset: a tag is only consulted while its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_store[index][victim_way] <= lookup_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_store[s] <= 2'b00;
            end
            lru_store <= '0;
        end else begin
            if (fill_en) begin
                valid_store[index][victim_way] <= 1'b1;
                lru_store[index]               <= ~victim_way;
            end else if (touch_en) begin
                lru_store[index] <= ~hit_way;
            end
            // Write-invalidate leaves the LRU bit untouched.
            if (inv_en) begin
                valid_store[index][hit_way] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate cache controller (tags only, data SRAM external).
// Latency: read hit 2 edges from request; read miss = memory latency + 4 edges; write = memory latency + 3 edges.
// Backpressure: ready_stall high while busy; CPU requests arriving then are dropped; memory latency unbounded.
//
// Ports:
//   clk, rst_n                 clock and async active-low reset
//   phy_addr, data_from_cpu    CPU byte address and write data, sampled with the request pulse
//   read_mem, write_mem        1-cycle request pulses; read wins if both are set
//   data_to_cpu, hit_miss      registered read data / last lookup result
//   ready_stall                1 while the controller is not idle
//   cache_mem_*                external data SRAM: set index, fill line, write strobe, matched-way read data
//   main_mem_*                 line read / word write requests, returned line and completion pulse
module cache_controller
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   phy_addr,
    input  logic [WORD_W-1:0]   data_from_cpu,
    input  logic                read_mem,
    input  logic                write_mem,
    output logic [WORD_W-1:0]   data_to_cpu,
    output logic                hit_miss,
    output logic                ready_stall,
    output logic [INDEX_W-1:0]  cache_mem_index,
    output logic [LINE_W-1:0]   cache_mem_data_in,
    output logic                cache_mem_write_en,
    input  logic [LINE_W-1:0]   cache_mem_data_out,
    output logic [ADDR_W-1:0]   main_mem_addr,
    output logic [WORD_W-1:0]   main_mem_data_out,
    output logic                main_mem_read_req,
    output logic                main_mem_write_req,
    input  logic [LINE_W-1:0]   main_mem_data_in,
    input  logic                main_mem_ready
);

    state_t             state;
    addr_t              reg_phy_addr;
    logic [WORD_W-1:0]  reg_wdata;
    logic               reg_is_write;
    logic [LINE_W-1:0]  fill_buf;

    logic               hit;
    logic               touch_en;
    logic               inv_en;
    logic               fill_en;
    logic [SETS-1:0]    lru_store;

    assign ready_stall       = (state != IDLE);
    // In IDLE the SRAM is addressed straight from the CPU so the matched-way data is ready in CHECK_HIT.
    assign cache_mem_index   = (state == IDLE) ? phy_addr[11:6] : reg_phy_addr.index;
    assign cache_mem_data_in = fill_buf;

    assign touch_en = (state == CHECK_HIT) && !reg_is_write && hit;
    assign inv_en   = (state == CHECK_HIT) &&  reg_is_write && hit;
    assign fill_en  = (state == FILL);

    cache_tag_array u_tags (
        .clk        (clk),
        .rst_n      (rst_n),
        .index      (reg_phy_addr.index),
        .lookup_tag (reg_phy_addr.tag),
        .hit        (hit),
        .touch_en   (touch_en),
        .inv_en     (inv_en),
        .fill_en    (fill_en),
        .lru_store  (lru_store)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            reg_phy_addr       <= '0;
            reg_wdata          <= '0;
            reg_is_write       <= 1'b0;
            fill_buf           <= '0;
            data_to_cpu        <= '0;
            hit_miss           <= 1'b0;
            cache_mem_write_en <= 1'b0;
            main_mem_addr      <= '0;
            main_mem_data_out  <= '0;
            main_mem_read_req  <= 1'b0;
            main_mem_write_req <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state below re-asserts them.
            main_mem_read_req  <= 1'b0;
            main_mem_write_req <= 1'b0;
            cache_mem_write_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (read_mem || write_mem) begin
                        reg_phy_addr <= addr_t'(phy_addr);
                        reg_wdata    <= data_from_cpu;
                        reg_is_write <= !read_mem;
                        state        <= CHECK_HIT;
                    end
                end

                CHECK_HIT: begin
                    if (!reg_is_write) begin
                        if (hit) begin
                            data_to_cpu <= line_word(cache_mem_data_out, reg_phy_addr.word);
                            hit_miss    <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            hit_miss          <= 1'b0;
                            main_mem_read_req <= 1'b1;
                            main_mem_addr     <= {reg_phy_addr.tag, reg_phy_addr.index,
                                                  {OFFSET_W{1'b0}}};
                            state             <= RD_REQ;
                        end
                    end else begin
                        // Write-through: every write goes to memory; a hit only drops the line.
                        hit_miss           <= hit;
                        main_mem_write_req <= 1'b1;
                        main_mem_addr      <= reg_phy_addr;
                        main_mem_data_out  <= reg_wdata;
                        state              <= WR_REQ;
                    end
                end

                RD_REQ: state <= RD_WAIT;

                RD_WAIT: begin
                    if (main_mem_ready) begin
                        fill_buf           <= main_mem_data_in;
                        cache_mem_write_en <= 1'b1;
                        state              <= FILL;
                    end
                end

                FILL: begin
                    data_to_cpu <= line_word(fill_buf, reg_phy_addr.word);
                    state       <= IDLE;
                end

                WR_REQ: state <= WR_WAIT;

                WR_WAIT: begin
                    if (main_mem_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed table, reset corner cases, randomized traffic vs model.
// Latency: n/a.
// Backpressure: memory responder answers each request after a random delay.
module tb_cache_controller;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  phy_addr = '0;
    logic [31:0]  data_from_cpu = '0;
    logic         read_mem = 1'b0;
    logic         write_mem = 1'b0;
    logic [31:0]  data_to_cpu;
    logic         hit_miss;
    logic         ready_stall;
    logic [5:0]   cache_mem_index;
    logic [511:0] cache_mem_data_in;
    logic         cache_mem_write_en;
    logic [511:0] cache_mem_data_out = '0;
    logic [31:0]  main_mem_addr;
    logic [31:0]  main_mem_data_out;
    logic         main_mem_read_req;
    logic         main_mem_write_req;
    logic [511:0] main_mem_data_in = '0;
    logic         main_mem_ready = 1'b0;

    cache_controller dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .phy_addr           (phy_addr),
        .data_from_cpu      (data_from_cpu),
        .read_mem           (read_mem),
        .write_mem          (write_mem),
        .data_to_cpu        (data_to_cpu),
        .hit_miss           (hit_miss),
        .ready_stall        (ready_stall),
        .cache_mem_index    (cache_mem_index),
        .cache_mem_data_in  (cache_mem_data_in),
        .cache_mem_write_en (cache_mem_write_en),
        .cache_mem_data_out (cache_mem_data_out),
        .main_mem_addr      (main_mem_addr),
        .main_mem_data_out  (main_mem_data_out),
        .main_mem_read_req  (main_mem_read_req),
        .main_mem_write_req (main_mem_write_req),
        .main_mem_data_in   (main_mem_data_in),
        .main_mem_ready     (main_mem_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- main memory and external SRAM models ----------------
    logic [31:0]  mem_w [logic [31:0]];
    logic [511:0] sram  [logic [31:0]];

    // Untouched memory word: block number, with the word number in the top byte.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (mem_w.exists(wa)) return mem_w[wa];
        return (wa >> 6) ^ (32'(wa[5:2]) << 24);
    endfunction

    function automatic logic [511:0] line_of(input logic [31:0] a);
        logic [511:0] l;
        l = '0;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = mem_rd({a[31:6], 4'(i), 2'b00});
        return l;
    endfunction

    // ---------------- cache reference model ----------------
    logic [19:0] m_tag [64][2];
    bit          m_val [64][2];
    int          m_mru [64];
    logic [31:0] m_last;

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_val[s][0] = 1'b0;
            m_val[s][1] = 1'b0;
            m_mru[s]    = 1;        // so the first victim is way 0
        end
        m_last = '0;
    endtask

    task automatic model_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             output bit ehit, output int erd, output int ewr);
        int s;
        int w;
        s = int'(a[11:6]);
        w = -1;
        for (int i = 0; i < 2; i++) if (m_val[s][i] && m_tag[s][i] == a[31:12]) w = i;
        ehit = (w >= 0);
        if (!wr) begin
            m_last = mem_rd(a);
            if (ehit) m_mru[s] = w;
            else begin
                m_tag[s][1 - m_mru[s]] = a[31:12];
                m_val[s][1 - m_mru[s]] = 1'b1;
                m_mru[s] = 1 - m_mru[s];
            end
            erd = ehit ? 0 : 1;
            ewr = 0;
        end else begin
            if (ehit) m_val[s][w] = 1'b0;
            mem_w[{a[31:2], 2'b00}] = d;
            erd = 0;
            ewr = 1;
        end
    endtask

    // ---------------- memory responder / SRAM monitor ----------------
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wdata = '0;
    bit          slow = 1'b0;
    int          n_rd = 0, n_wr = 0, n_fill = 0;
    int          pend = 0;

    initial begin
        forever begin
            @(negedge clk);
            main_mem_ready = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) main_mem_ready = 1'b1;
            end
            if (main_mem_read_req) begin
                n_rd++;
                check("rd_addr", 64'(main_mem_addr), 64'({cur_addr[31:6], 6'd0}));
                main_mem_data_in = line_of(cur_addr);
                pend = int'($urandom_range(1, 5)) + (slow ? 8 : 0);
            end
            if (main_mem_write_req) begin
                n_wr++;
                check("wr_addr", 64'(main_mem_addr), 64'(cur_addr));
                check("wr_data", 64'(main_mem_data_out), 64'(cur_wdata));
                pend = int'($urandom_range(1, 5));
            end
            if (cache_mem_write_en) begin
                n_fill++;
                check("fill_index", 64'(cache_mem_index), 64'(cur_addr[11:6]));
                check("fill_line", 64'(cache_mem_data_in != line_of(cur_addr)), 64'd0);
                sram[{cur_addr[31:6], 6'd0}] = cache_mem_data_in;
            end
        end
    end

    // One CPU request; returns negedges from request drop to ready_stall low.
    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input bit poke, output int cyc);
        logic [31:0] line;
        line      = {a[31:6], 6'd0};
        cur_addr  = a;
        cur_wdata = d;
        if (sram.exists(line)) cache_mem_data_out = sram[line];
        else                   cache_mem_data_out = {16{32'hDEAD_BEEF}};
        n_rd = 0; n_wr = 0; n_fill = 0;
        @(negedge clk);
        phy_addr = a; data_from_cpu = d; read_mem = !wr; write_mem = wr;
        @(negedge clk);
        read_mem = 1'b0; write_mem = 1'b0; phy_addr = $urandom; data_from_cpu = $urandom;
        cyc = 0;
        while (ready_stall && cyc < 300) begin
            @(negedge clk);
            cyc++;
            write_mem = 1'b0;
            // A request while busy must be dropped.
            if (poke && cyc == 2 && ready_stall) write_mem = 1'b1;
        end
        write_mem = 1'b0;
        check("stall_released", 64'(ready_stall), 64'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_hit;
        logic [31:0] exp_data;
        int          exp_rd;
        int          exp_wr;
        bit          exp_victim;
    } vec_t;

    initial begin
        vec_t        tbl [13];
        bit          wr;
        bit          ehit;
        bit          stuck;
        logic [31:0] a;
        logic [31:0] d;
        int          erd, ewr, cyc, s;

        // set 0 walk-through: fills, LRU eviction, write-through miss, write-invalidate
        tbl[0]  = '{0, 32'h0000_1000, 32'h0,         0, 32'h0000_0040, 1, 0, 1};
        tbl[1]  = '{0, 32'h0000_1000, 32'h0,         1, 32'h0000_0040, 0, 0, 1};
        tbl[2]  = '{1, 32'h0000_2000, 32'hCAFE_BABE, 0, 32'h0000_0040, 0, 1, 1};
        tbl[3]  = '{0, 32'h0004_1000, 32'h0,         0, 32'h0000_1040, 1, 0, 0};
        tbl[4]  = '{0, 32'h0008_1000, 32'h0,         0, 32'h0000_2040, 1, 0, 1};
        tbl[5]  = '{0, 32'h0004_1000, 32'h0,         1, 32'h0000_1040, 0, 0, 0};
        tbl[6]  = '{1, 32'h0004_1000, 32'h1234_5678, 1, 32'h0000_1040, 0, 1, 0};
        tbl[7]  = '{0, 32'h0004_1000, 32'h0,         0, 32'h1234_5678, 1, 0, 1};
        tbl[8]  = '{0, 32'h0000_1000, 32'h0,         0, 32'h0000_0040, 1, 0, 0};
        tbl[9]  = '{0, 32'h0000_1004, 32'h0,         1, 32'h0100_0040, 0, 0, 0};
        tbl[10] = '{0, 32'h0000_2000, 32'h0,         0, 32'hCAFE_BABE, 1, 0, 1};
        tbl[11] = '{0, 32'h0008_1000, 32'h0,         0, 32'h0000_2040, 1, 0, 0};
        tbl[12] = '{0, 32'h0000_1000, 32'h0,         0, 32'h0000_0040, 1, 0, 1};

        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",     64'(data_to_cpu), 64'd0);
        check("rst_hit",      64'(hit_miss), 64'd0);
        check("rst_stall",    64'(ready_stall), 64'd0);
        check("rst_index",    64'(cache_mem_index), 64'd0);
        check("rst_wen",      64'(cache_mem_write_en), 64'd0);
        check("rst_line",     64'(cache_mem_data_in != '0), 64'd0);
        check("rst_mem_addr", 64'(main_mem_addr), 64'd0);
        check("rst_mem_data", 64'(main_mem_data_out), 64'd0);
        check("rst_reqs",     64'({main_mem_read_req, main_mem_write_req}), 64'd0);
        check("rst_lru",      64'(dut.lru_store), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, cyc);
            model_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, ehit, erd, ewr);
            check($sformatf("row%0d_hit", i),    64'(hit_miss), 64'(tbl[i].exp_hit));
            check($sformatf("row%0d_data", i),   64'(data_to_cpu), 64'(tbl[i].exp_data));
            check($sformatf("row%0d_rdreq", i),  64'(n_rd), 64'(tbl[i].exp_rd));
            check($sformatf("row%0d_wrreq", i),  64'(n_wr), 64'(tbl[i].exp_wr));
            check($sformatf("row%0d_fill", i),   64'(n_fill), 64'(tbl[i].exp_rd));
            check($sformatf("row%0d_victim", i), 64'(dut.lru_store[0]), 64'(tbl[i].exp_victim));
            if (!tbl[i].wr && tbl[i].exp_hit)
                check($sformatf("row%0d_hit_latency", i), 64'(cyc), 64'd1);
        end

        // Reset while waiting on a line read; the late memory response must be ignored.
        slow = 1'b1;
        cur_addr = 32'h0000_3000;
        cache_mem_data_out = {16{32'hDEAD_BEEF}};
        @(negedge clk);
        phy_addr = 32'h0000_3000; read_mem = 1'b1;
        @(negedge clk);
        read_mem = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_reset", 64'(ready_stall), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_stall", 64'(ready_stall), 64'd0);
        check("midrst_hit",   64'(hit_miss), 64'd0);
        check("midrst_data",  64'(data_to_cpu), 64'd0);
        check("midrst_lru",   64'(dut.lru_store), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        slow = 1'b0;
        stuck = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (ready_stall || cache_mem_write_en) stuck = 1'b1;
        end
        check("late_ready_ignored", 64'(stuck), 64'd0);
        model_reset();

        // Everything was invalidated: the previously cached line must miss.
        do_txn(1'b0, 32'h0000_1000, 32'h0, 1'b0, cyc);
        model_txn(1'b0, 32'h0000_1000, 32'h0, ehit, erd, ewr);
        check("post_reset_hit",  64'(hit_miss), 64'd0);
        check("post_reset_data", 64'(data_to_cpu), 64'(m_last));
        check("post_reset_rd",   64'(n_rd), 64'd1);

        // Random traffic over 4 tags x 3 sets so both ways thrash.
        for (int k = 0; k < 300; k++) begin
            wr = ($urandom_range(0, 9) < 3);
            a  = {20'($urandom_range(0, 3)) * 20'h40 + 20'h1, 6'($urandom_range(0, 2)),
                  4'($urandom_range(0, 15)), 2'b00};
            d  = $urandom;
            s  = int'(a[11:6]);
            do_txn(wr, a, d, ($urandom_range(0, 9) == 0), cyc);
            model_txn(wr, a, d, ehit, erd, ewr);
            check($sformatf("rnd%0d_hit", k),    64'(hit_miss), 64'(ehit));
            check($sformatf("rnd%0d_data", k),   64'(data_to_cpu), 64'(m_last));
            check($sformatf("rnd%0d_rdreq", k),  64'(n_rd), 64'(erd));
            check($sformatf("rnd%0d_wrreq", k),  64'(n_wr), 64'(ewr));
            check($sformatf("rnd%0d_fill", k),   64'(n_fill), 64'(erd));
            check($sformatf("rnd%0d_victim", k), 64'(dut.lru_store[s]), 64'(1 - m_mru[s]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
